// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage: one-entry register or two-entry skid buffer with
// synchronous flush (with saturating discard counter) and synchronous reset.
//
// Handshake: an entry moves across a port only on a cycle where valid and
// ready are both high at the rising edge; valid never depends on ready.
module elastic_pipe_reg #(
  parameter int unsigned       DATA_W  = 16,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [7:0]        flush_cnt
);

  // Encoding equals the held-entry count, so occupancy exposes the state directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [7:0]        flush_cnt_q, flush_cnt_d;
  logic [8:0]        flush_sum;
  logic [1:0]        discard;
  logic              accept;
  logic              consume;

  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VAL;
  assign occupancy = state_q;
  assign flush_cnt = flush_cnt_q;

  generate
    if (SKID_EN) begin : g_skid_ready
      logic rdy_q;
      always_ff @(posedge clk) begin
        if (reset) rdy_q <= 1'b1;
        else       rdy_q <= (state_d != ST_FULL);
      end
      // Reset gating keeps entries out while reset is held; out_ready never reaches here.
      assign in_ready = rdy_q & ~reset;
    end else begin : g_pass_ready
      assign in_ready = (~out_valid | out_ready) & ~reset;
    end
  endgenerate

  // Entries consumed on the flush cycle left normally and are not discards.
  assign discard     = flush ? (occupancy - {1'b0, consume}) : 2'd0;
  assign flush_sum   = {1'b0, flush_cnt_q} + {7'd0, discard};
  assign flush_cnt_d = flush_sum[8] ? 8'hFF : flush_sum[7:0];

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_VAL;
      skid_q      <= NOP_VAL;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
